// File: rtl/issue_unit.sv
// Single-issue decode/dispatch stage with an internal 8x32 register file.
// One instruction is in flight at a time. It drives the alu, branch and data_mov
// execute units and writes their results back to the register file.
module issue_unit #(
  parameter int unsigned DMOV_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  opcode,
  output logic        has_imm,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] xd,
  output logic [20:0] imm,
  output logic        alu_en,
  output logic        br_en,
  output logic        dmov_en,
  input  logic [31:0] alu_y,
  input  logic [31:0] br_offset,
  input  logic        br_taken,
  input  logic [31:0] dmov_y,
  input  logic [1:0]  dmov_write_which,
  input  logic        dmov_done,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic        halted,
  output logic [31:0] retired
);

  // The counter only has to reach DMOV_TIMEOUT-1; expiry is decided in that cycle.
  localparam int unsigned CntW = (DMOV_TIMEOUT > 1) ? $clog2(DMOV_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DMOV_TIMEOUT - 1);

  localparam logic [2:0] ClsAluR = 3'b000;
  localparam logic [2:0] ClsAluI = 3'b001;
  localparam logic [2:0] ClsBr   = 3'b010;
  localparam logic [2:0] ClsDmov = 3'b011;
  localparam logic [2:0] ClsHalt = 3'b111;

  typedef enum logic [2:0] {StIdle, StIssue, StExec, StWait, StHalt} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cls_q, cls_d;
  logic [2:0]      rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            instr_ready_q, instr_ready_d;
  logic [2:0]      opcode_q, opcode_d;
  logic            has_imm_q, has_imm_d;
  logic [31:0]     x1_q, x1_d, x2_q, x2_d, xd_q, xd_d;
  logic [20:0]     imm_q, imm_d;
  logic            alu_en_q, alu_en_d, br_en_q, br_en_d, dmov_en_q, dmov_en_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            err_illegal_q, err_illegal_d;
  logic            err_timeout_q, err_timeout_d;
  logic            halted_q, halted_d;
  logic [31:0]     retired_q, retired_d;

  logic [31:0]     rf_q [8];
  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic [31:0]     rf_wdata;

  logic [2:0]      in_cls, in_rd, in_rs1, in_rs2;
  logic [31:0]     rs1_val, rs2_val, rd_val;
  logic            accept, active;

  assign in_cls = instr[31:29];
  assign in_rd  = instr[25:23];
  assign in_rs1 = instr[22:20];
  assign in_rs2 = instr[19:17];

  // r0 is hardwired to zero on the read side.
  assign rs1_val = (in_rs1 == 3'd0) ? 32'd0 : rf_q[in_rs1];
  assign rs2_val = (in_rs2 == 3'd0) ? 32'd0 : rf_q[in_rs2];
  assign rd_val  = (in_rd  == 3'd0) ? 32'd0 : rf_q[in_rd];

  assign accept = (state_q == StIdle) && instr_ready_q && instr_valid;

  // Next-state, writeback and registered-output computation.
  always_comb begin
    state_d          = state_q;
    cls_d            = cls_q;
    rd_d             = rd_q;
    cnt_d            = cnt_q;
    opcode_d         = opcode_q;
    has_imm_d        = has_imm_q;
    x1_d             = x1_q;
    x2_d             = x2_q;
    xd_d             = xd_q;
    imm_d            = imm_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    err_illegal_d    = 1'b0;
    err_timeout_d    = 1'b0;
    halted_d         = halted_q;
    retired_d        = retired_q;
    rf_we            = 1'b0;
    rf_waddr         = rd_q;
    rf_wdata         = alu_y;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (in_cls)
            ClsAluR, ClsAluI, ClsBr, ClsDmov: begin
              state_d   = StIssue;
              cls_d     = in_cls;
              rd_d      = in_rd;
              opcode_d  = instr[28:26];
              has_imm_d = (in_cls == ClsAluI);
              x1_d      = rs1_val;
              x2_d      = rs2_val;
              xd_d      = rd_val;
              imm_d     = {{4{instr[16]}}, instr[16:0]};
            end
            ClsHalt: begin
              state_d   = StHalt;
              halted_d  = 1'b1;
              retired_d = retired_q + 32'd1;
            end
            default: err_illegal_d = 1'b1;
          endcase
        end
      end
      StIssue: state_d = StExec;
      StExec: begin
        case (cls_q)
          ClsAluR, ClsAluI: begin
            rf_we     = 1'b1;
            retired_d = retired_q + 32'd1;
            state_d   = StIdle;
          end
          ClsBr: begin
            redirect_valid_d = br_taken;
            if (br_taken) redirect_pc_d = br_offset;
            retired_d = retired_q + 32'd1;
            state_d   = StIdle;
          end
          ClsDmov: begin
            cnt_d   = '0;
            state_d = StWait;
          end
          default: state_d = StIdle;
        endcase
      end
      StWait: begin
        // Completion takes priority over a coincident timeout.
        if (dmov_done) begin
          rf_we     = (dmov_write_which == 2'b01);
          rf_wdata  = dmov_y;
          retired_d = retired_q + 32'd1;
          state_d   = StIdle;
        end else if (cnt_q == CntLast) begin
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    instr_ready_d = (state_d == StIdle);
    active        = (state_d == StIssue) || (state_d == StExec) || (state_d == StWait);
    alu_en_d      = active && ((cls_d == ClsAluR) || (cls_d == ClsAluI));
    br_en_d       = active && (cls_d == ClsBr);
    dmov_en_d     = active && (cls_d == ClsDmov);
  end

  // State and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      cls_q            <= 3'd0;
      rd_q             <= 3'd0;
      cnt_q            <= '0;
      instr_ready_q    <= 1'b0;
      opcode_q         <= 3'd0;
      has_imm_q        <= 1'b0;
      x1_q             <= 32'd0;
      x2_q             <= 32'd0;
      xd_q             <= 32'd0;
      imm_q            <= 21'd0;
      alu_en_q         <= 1'b0;
      br_en_q          <= 1'b0;
      dmov_en_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      err_illegal_q    <= 1'b0;
      err_timeout_q    <= 1'b0;
      halted_q         <= 1'b0;
      retired_q        <= 32'd0;
    end else begin
      state_q          <= state_d;
      cls_q            <= cls_d;
      rd_q             <= rd_d;
      cnt_q            <= cnt_d;
      instr_ready_q    <= instr_ready_d;
      opcode_q         <= opcode_d;
      has_imm_q        <= has_imm_d;
      x1_q             <= x1_d;
      x2_q             <= x2_d;
      xd_q             <= xd_d;
      imm_q            <= imm_d;
      alu_en_q         <= alu_en_d;
      br_en_q          <= br_en_d;
      dmov_en_q        <= dmov_en_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      err_illegal_q    <= err_illegal_d;
      err_timeout_q    <= err_timeout_d;
      halted_q         <= halted_d;
      retired_q        <= retired_d;
    end
  end

  // Register file; writes to r0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 32'd0;
    end else if (rf_we && (rf_waddr != 3'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign instr_ready    = instr_ready_q;
  assign opcode         = opcode_q;
  assign has_imm        = has_imm_q;
  assign x1             = x1_q;
  assign x2             = x2_q;
  assign xd             = xd_q;
  assign imm            = imm_q;
  assign alu_en         = alu_en_q;
  assign br_en          = br_en_q;
  assign dmov_en        = dmov_en_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign err_illegal    = err_illegal_q;
  assign err_timeout    = err_timeout_q;
  assign halted         = halted_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: stimulus pushes expected events, a monitor
// pops and compares them whenever the DUT presents an observable event.
module tb_issue_unit;

  localparam int unsigned TO = 16;

  localparam int KEn = 0, KX1 = 1, KX2 = 2, KXd = 3, KImm = 4, KRet = 5, KRdr = 6;
  localparam int KIll = 7, KTmo = 8, KHalt = 9, KRdy = 10;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic        has_imm;
  logic [31:0] x1, x2, xd;
  logic [20:0] imm;
  logic        alu_en, br_en, dmov_en;
  logic [31:0] alu_y = '0;
  logic [31:0] br_offset = '0;
  logic        br_taken = 1'b0;
  logic [31:0] dmov_y = '0;
  logic [1:0]  dmov_write_which = 2'b00;
  logic        dmov_done = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        err_illegal, err_timeout, halted;
  logic [31:0] retired;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];

  issue_unit #(.DMOV_TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .opcode           (opcode),
    .has_imm          (has_imm),
    .x1               (x1),
    .x2               (x2),
    .xd               (xd),
    .imm              (imm),
    .alu_en           (alu_en),
    .br_en            (br_en),
    .dmov_en          (dmov_en),
    .alu_y            (alu_y),
    .br_offset        (br_offset),
    .br_taken         (br_taken),
    .dmov_y           (dmov_y),
    .dmov_write_which (dmov_write_which),
    .dmov_done        (dmov_done),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .err_illegal      (err_illegal),
    .err_timeout      (err_timeout),
    .halted           (halted),
    .retired          (retired)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  function automatic string kname(input int k);
    case (k)
      KEn:     return "enable";
      KX1:     return "x1";
      KX2:     return "x2";
      KXd:     return "xd";
      KImm:    return "imm";
      KRet:    return "retired";
      KRdr:    return "redirect";
      KIll:    return "err_illegal";
      KTmo:    return "err_timeout";
      KHalt:   return "halted";
      default: return "instr_ready";
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [2:0] cls, input logic [2:0] op,
                                      input logic [2:0] rd, input logic [2:0] rs1,
                                      input logic [2:0] rs2, input logic [16:0] i17);
    return {cls, op, rd, rs1, rs2, i17};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int k, input int c, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic see(input int k, input logic [31:0] v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected %s: got %h at cycle %0d want no event", kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (e.cyc >= 0 && e.cyc != cyc) || e.val !== v) begin
        n_bad++;
        $display("FAIL %s: got %s=%h @%0d want %s=%h @%0d", kname(e.kind), kname(k), v, cyc,
                 kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  // Monitor: sample away from the active edge and turn output activity into events.
  initial begin
    logic [2:0]  en_now, en_prev;
    logic [31:0] ret_prev;
    logic        halt_prev, rdy_prev;
    en_prev = '0; ret_prev = '0; halt_prev = 1'b0; rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      en_now = {alu_en, br_en, dmov_en};
      if (en_now != 3'b000 && en_prev == 3'b000) begin
        see(KEn, {25'd0, en_now, opcode, has_imm});
        see(KX1, x1);
        see(KX2, x2);
        see(KXd, xd);
        see(KImm, {11'd0, imm});
      end
      if (retired !== ret_prev) see(KRet, retired);
      if (redirect_valid) see(KRdr, redirect_pc);
      if (err_illegal) see(KIll, 32'd0);
      if (err_timeout) see(KTmo, 32'd0);
      if (halted && !halt_prev) see(KHalt, 32'd0);
      if (instr_ready && !rdy_prev) see(KRdy, 32'd0);
      en_prev   = en_now;
      ret_prev  = retired;
      halt_prev = halted;
      rdy_prev  = instr_ready;
    end
  end

  // Offer an instruction; returns at the negedge of the accept cycle (or n = -1).
  task automatic send(input logic [31:0] w, output int n);
    instr       = w;
    instr_valid = 1'b1;
    n = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept: got no instr_ready in 100 cycles want accept");
    end
  endtask

  task automatic drop();
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w, input logic [2:0] en, input logic [31:0] x1e,
                       input logic [31:0] x2e, input logic [31:0] xde, input logic [20:0] ime,
                       output int n);
    send(w, n);
    if (n >= 0) begin
      expect_ev(KEn, n + 1, {25'd0, en, w[28:26], (w[31:29] == 3'b001)});
      expect_ev(KX1, n + 1, x1e);
      expect_ev(KX2, n + 1, x2e);
      expect_ev(KXd, n + 1, xde);
      expect_ev(KImm, n + 1, {11'd0, ime});
    end
  endtask

  task automatic run_alu(input logic [31:0] w, input logic [31:0] y, input logic [31:0] x1e,
                         input logic [31:0] x2e, input logic [31:0] xde, input logic [20:0] ime,
                         input logic [31:0] ret);
    int n;
    alu_y = y;
    issue(w, 3'b100, x1e, x2e, xde, ime, n);
    if (n >= 0) begin
      expect_ev(KRet, n + 3, ret);
      expect_ev(KRdy, n + 3, 32'd0);
    end
    drop();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_br(input logic [31:0] w, input logic tk, input logic [31:0] off,
                        input logic [31:0] x1e, input logic [31:0] x2e, input logic [31:0] xde,
                        input logic [20:0] ime, input logic [31:0] ret);
    int n;
    br_taken  = tk;
    br_offset = off;
    issue(w, 3'b010, x1e, x2e, xde, ime, n);
    if (n >= 0) begin
      expect_ev(KRet, n + 3, ret);
      if (tk) expect_ev(KRdr, n + 3, off);
      expect_ev(KRdy, n + 3, 32'd0);
    end
    drop();
    repeat (2) @(posedge clk);
    #1 br_taken = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    expect_ev(KRdy, cyc + 1, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_instr_ready", {31'd0, instr_ready}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_enables", {29'd0, alu_en, br_en, dmov_en}, 32'd0);
    chk("reset_x1", x1, 32'd0);
    release_reset();

    // ALU immediate into r1, then register op reading it back with negative imm.
    run_alu(enc(3'b001, 3'b000, 3'd1, 3'd0, 3'd0, 17'd5), 32'd5,
            32'd0, 32'd0, 32'd0, 21'd5, 32'd1);
    run_alu(enc(3'b000, 3'b010, 3'd2, 3'd1, 3'd1, 17'h1FFFF), 32'h0A,
            32'd5, 32'd5, 32'd0, 21'h1FFFFF, 32'd2);
    // Write to r0 is discarded; the following read of r0 returns zero.
    run_alu(enc(3'b001, 3'b001, 3'd0, 3'd2, 3'd0, 17'd3), 32'h1234,
            32'h0A, 32'd0, 32'd0, 21'd3, 32'd3);
    run_alu(enc(3'b000, 3'b000, 3'd0, 3'd0, 3'd2, 17'd0), 32'h77,
            32'd0, 32'h0A, 32'd0, 21'd0, 32'd4);

    // Branches: taken then not taken.
    run_br(enc(3'b010, 3'b011, 3'd1, 3'd1, 3'd2, 17'h10), 1'b1, 32'h40,
           32'd5, 32'h0A, 32'd5, 21'h10, 32'd5);
    run_br(enc(3'b010, 3'b100, 3'd0, 3'd0, 3'd0, 17'h1FFF0), 1'b0, 32'h80,
           32'd0, 32'd0, 32'd0, 21'h1FFFF0, 32'd6);

    // Data-move load into r3 completing in WAIT.
    dmov_y = 32'hDEAD;
    dmov_write_which = 2'b01;
    issue(enc(3'b011, 3'b001, 3'd3, 3'd2, 3'd0, 17'd8), 3'b001,
          32'h0A, 32'd0, 32'd0, 21'd8, n);
    if (n >= 0) begin
      expect_ev(KRet, n + 6, 32'd7);
      expect_ev(KRdy, n + 6, 32'd0);
    end
    drop();
    repeat (4) @(posedge clk);
    #1 dmov_done = 1'b1;
    @(posedge clk);
    #1 dmov_done = 1'b0;
    run_alu(enc(3'b000, 3'b000, 3'd4, 3'd3, 3'd0, 17'd0), 32'd0,
            32'hDEAD, 32'd0, 32'd0, 21'd0, 32'd8);

    // Data-move load that never completes: timeout, no writeback, no retire.
    dmov_y = 32'hBEEF;
    issue(enc(3'b011, 3'b000, 3'd3, 3'd0, 3'd0, 17'd0), 3'b001,
          32'd0, 32'd0, 32'hDEAD, 21'd0, n);
    if (n >= 0) begin
      expect_ev(KTmo, n + 3 + TO, 32'd0);
      expect_ev(KRdy, n + 3 + TO, 32'd0);
    end
    drop();
    run_alu(enc(3'b000, 3'b000, 3'd5, 3'd3, 3'd0, 17'd0), 32'h55,
            32'hDEAD, 32'd0, 32'd0, 21'd0, 32'd9);

    // Illegal class: error pulse only; the next retire proves no count was taken.
    send(enc(3'b101, 3'b000, 3'd1, 3'd1, 3'd1, 17'd0), n);
    if (n >= 0) expect_ev(KIll, n + 1, 32'd0);
    drop();
    run_alu(enc(3'b001, 3'b111, 3'd6, 3'd4, 3'd0, 17'd1), 32'h99,
            32'd0, 32'd0, 32'd0, 21'd1, 32'd10);

    // Reset while a data move waits: everything clears asynchronously.
    issue(enc(3'b011, 3'b010, 3'd7, 3'd1, 3'd0, 17'd0), 3'b001,
          32'd5, 32'd0, 32'd0, 21'd0, n);
    expect_ev(KRet, -1, 32'd0);
    drop();
    repeat (3) @(posedge clk);
    #2;
    chk("wait_dmov_en", {31'd0, dmov_en}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_dmov_en", {31'd0, dmov_en}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_x1", x1, 32'd0);
    chk("rst_opcode", {29'd0, opcode}, 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    run_alu(enc(3'b000, 3'b000, 3'd1, 3'd1, 3'd3, 17'd0), 32'h11,
            32'd0, 32'd0, 32'd0, 21'd0, 32'd1);

    // Halt: counts as retired, then instr_ready stays low.
    send(enc(3'b111, 3'b000, 3'd0, 3'd0, 3'd0, 17'd0), n);
    if (n >= 0) begin
      expect_ev(KRet, n + 1, 32'd2);
      expect_ev(KHalt, n + 1, 32'd0);
    end
    drop();
    instr = enc(3'b000, 3'b000, 3'd1, 3'd1, 3'd1, 17'd0);
    instr_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("halt_instr_ready", {31'd0, instr_ready}, 32'd0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_alu_en", {31'd0, alu_en}, 32'd0);
    instr_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
